// File: rtl/conv2d_output_collector_if.sv
// conv2d_output_collector_if: result stream in, filtered results out, plus sticky overflow flag
// master = producer/consumer side, slave = collector side
interface conv2d_output_collector_if #(
  parameter int bitWidth = 8
);
  logic                       in_valid;
  logic signed [bitWidth-1:0] in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [bitWidth-1:0] out_data;
  logic                       out_last;
  logic                       overflow;
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, overflow
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, overflow
  );
endinterface

// File: rtl/conv2d_output_collector.sv
// conv2d_output_collector: keeps only full-window conv results, tags frame end, queues them in a FIFO
// clock: rising-edge clock; reset: sync active-low; bus: result stream in, valid/ready out, sticky overflow
module conv2d_output_collector #(
  parameter int filtDimension = 3,
  parameter int bitWidth      = 8,
  parameter int inputWidth    = 8,
  parameter int inputHeight   = 8,
  parameter int fifoDepth     = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  conv2d_output_collector_if.slave    bus
);
  localparam int CW = $clog2(inputWidth);
  localparam int RW = $clog2(inputHeight);
  localparam int AW = $clog2(fifoDepth);
  localparam int NW = AW + 1;
  localparam logic [CW-1:0] COL_MIN = CW'(filtDimension - 1);
  localparam logic [CW-1:0] COL_END = CW'(inputWidth - 1);
  localparam logic [RW-1:0] ROW_MIN = RW'(filtDimension - 1);
  localparam logic [RW-1:0] ROW_END = RW'(inputHeight - 1);
  localparam logic [NW-1:0] FULL    = NW'(fifoDepth);
  logic [CW-1:0]              col;
  logic [RW-1:0]              row;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [NW-1:0]              count;
  logic signed [bitWidth-1:0] mem_data [fifoDepth];
  logic                       mem_last [fifoDepth];
  logic                       col_end, row_end, win, full, pop, push;
  assign col_end = col == COL_END;
  assign row_end = row == ROW_END;
  assign win     = col >= COL_MIN && row >= ROW_MIN;
  assign full    = count == FULL;
  assign pop     = bus.out_valid & bus.out_ready;
  // a full FIFO still accepts when its head leaves on the same edge
  assign push    = bus.in_valid & win & (!full | pop);
  assign bus.out_valid = count != '0;
  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_last  = mem_last[rd_ptr];
  always_ff @(posedge clock) begin
    if (!reset) begin
      col          <= '0;
      row          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.overflow <= 1'b0;
      for (int i = 0; i < fifoDepth; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else begin
      if (bus.in_valid) begin
        col <= col_end ? '0 : col + 1'b1;
        if (col_end) row <= row_end ? '0 : row + 1'b1;
      end
      if (push) begin
        mem_data[wr_ptr] <= bus.in_data;
        mem_last[wr_ptr] <= col_end & row_end;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + NW'(push) - NW'(pop);
      if (bus.in_valid & win & full & !pop) bus.overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_conv2d_output_collector.sv
// tb_conv2d_output_collector: scoreboard bench for the conv2d output collector
module tb_conv2d_output_collector;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  conv2d_output_collector_if #(.bitWidth(8)) bus ();
  conv2d_output_collector #(
    .filtDimension(3), .bitWidth(8), .inputWidth(8), .inputHeight(8), .fifoDepth(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  typedef struct {
    logic signed [7:0] d;
    logic              l;
  } exp_t;
  exp_t q[$];
  int   checks = 0, failures = 0;
  int   mcol = 0, mrow = 0, n_out = 0, n_last = 0;
  logic movf = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic v, input int d, input logic rdy);
    exp_t e;
    @(negedge clock);
    check("overflow", 32'(bus.overflow), 32'(movf));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() > 0) begin
      check("out_data", 32'(bus.out_data), 32'(q[0].d));
      check("out_last", 32'(bus.out_last), 32'(q[0].l));
      if (rdy) begin
        n_out++;
        if (q[0].l) n_last++;
        void'(q.pop_front());
      end
    end
    bus.in_valid  = v;
    bus.in_data   = d[7:0];
    bus.out_ready = rdy;
    if (v) begin
      if (mcol >= 2 && mrow >= 2) begin
        e.d = d[7:0];
        e.l = (mcol == 7 && mrow == 7);
        if (q.size() < 4) q.push_back(e);
        else movf = 1'b1;
      end
      mcol++;
      if (mcol == 8) begin
        mcol = 0;
        mrow = (mrow == 7) ? 0 : mrow + 1;
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_last", 32'(bus.out_last), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    q.delete();
    mcol = 0;
    mrow = 0;
    movf = 1'b0;
  endtask
  task automatic frame(input logic gap, input int mode);
    logic r;
    for (int i = 0; i < 64; i++) begin
      r = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
      step(1'b1, i, r);
      if (gap) step(1'b0, 8'hAA, r);
    end
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1);
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    do_reset();
    frame(1'b0, 1);
    drain(4);
    check("frame_count", 32'(n_out), 36);
    check("frame_last", 32'(n_last), 1);
    n_out = 0;
    frame(1'b1, 1);
    drain(4);
    check("gap_count", 32'(n_out), 36);
    frame(1'b0, 0);
    check("bp_ovf_model", 32'(movf), 1);
    drain(6);
    do_reset();
    for (int i = 0; i < 22; i++) step(1'b1, i, 1'b0);
    for (int i = 22; i < 64; i++) step(1'b1, i, 1'b1);
    drain(6);
    n_out = 0;
    n_last = 0;
    frame(1'b0, 1);
    frame(1'b0, 1);
    drain(4);
    check("b2b_count", 32'(n_out), 72);
    check("b2b_last", 32'(n_last), 2);
    for (int i = 0; i <= 30; i++) step(1'b1, i, 1'b0);
    do_reset();
    frame(1'b0, 1);
    drain(4);
    frame(1'b0, 2);
    drain(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
